traffic_intersection_ctrl: RTL and testbench
============================================

# traffic_intersection_ctrl

Parametrised two-approach intersection controller with a main road, a side road and a pedestrian crossing. It is the successor to the single-approach RED/GREEN/YELLOW sequencer. It adds side-road demand sensing, a latched pedestrian request, an all-red clearance interval, a heavy-traffic green extension and a night flashing mode. All phase durations are parameters. The block drives the lamp drivers directly and exports its current phase for monitoring.

## Interface
Parameters:
- `CNT_W`, 8: phase counter width; every duration must be in 1..2^CNT_W.
- `T_MG`, 32: main green minimum, cycles.
- `T_MG_EXT`, 64: main green minimum when `heavy_main`=1; must be ≥ `T_MG`.
- `T_SG`, 16: side green, cycles.
- `T_Y`, 4: yellow, both approaches.
- `T_AR`, 2: all-red clearance.
- `T_WALK`, 8: walk lamp duration; must be ≤ `T_SG`.
- `T_FLASH`, 16: half-period of the night flash.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `heavy_main`  in  1  level input; selects `T_MG_EXT`.
- `side_req`  in  1  level input; side-road vehicle sensor.
- `ped_req`  in  1  pulse or level input; pedestrian button.
- `night_mode`  in  1  level input; requests flashing operation.
- `main_rgy`  out  3  {red, yellow, green} for the main road.
- `side_rgy`  out  3  {red, yellow, green} for the side road.
- `ped_walk`  out  1  walk lamp.
- `ped_pending`  out  1  a pedestrian request is latched and not yet served.
- `phase`  out  3  current FSM state, encoded per the package.

## Operation
- FSM states: `MAIN_GREEN`, `MAIN_YELLOW`, `ALL_RED_1`, `SIDE_GREEN`, `SIDE_YELLOW`, `ALL_RED_2`, `FLASH`.
- A phase of duration T lasts exactly T cycles. `cnt` counts 0..T-1 and the state advances on the edge where `cnt`==T-1. `cnt` clears to 0 on every state change.
- `MAIN_GREEN` has two terminal counts:
  - Terminal = `heavy_main` ? `T_MG_EXT`-1 : `T_MG`-1, re-evaluated every cycle.
  - Expired means `cnt` ≥ terminal. Lowering `heavy_main` mid-phase may therefore expire the phase at once.
  - Once expired, the FSM moves to `MAIN_YELLOW` only if `side_req`=1 or `ped_pending`=1. Otherwise it holds `MAIN_GREEN` indefinitely, with `cnt` saturating at `T_MG_EXT`-1.
- Fixed sequence: `MAIN_YELLOW`(T_Y) → `ALL_RED_1`(T_AR) → `SIDE_GREEN`(T_SG) → `SIDE_YELLOW`(T_Y) → `ALL_RED_2`(T_AR) → `MAIN_GREEN`.
- Pedestrian request latch:
  - `ped_pending` sets on any cycle with `ped_req`=1.
  - It clears on the edge entering `SIDE_GREEN`, and the walk flag is captured on that same edge.
  - If `ped_req`=1 on that same edge, `ped_pending` stays set, for the next cycle of the sequence.
- `ped_walk`=1 during `SIDE_GREEN` only while the walk flag is set and `cnt` < `T_WALK`. Otherwise it is 0.
- Night mode:
  - Entry: `night_mode` is sampled only at the terminal count of `ALL_RED_1` or `ALL_RED_2`. If it is 1, the next state is `FLASH` instead of the normal successor.
  - In `FLASH`, a toggle bit flips every `T_FLASH` cycles, starting at 1 on entry. Lamps: `main_rgy`={0,tog,0}, `side_rgy`={tog,0,0}, `ped_walk`=0.
  - Requests still latch into `ped_pending` while in `FLASH`.
  - Exit: when `night_mode`=0, the next edge goes to `ALL_RED_2`, which then completes the full `T_AR` cycles.
- Lamp decode is a combinational function of state, `cnt`, the toggle bit and the walk flag. Exactly one lamp per approach is lit, except in `FLASH`.
- Non-flash lamp values:
  - `MAIN_GREEN`: main 001, side 100.
  - `MAIN_YELLOW`: main 010, side 100.
  - `ALL_RED_1` and `ALL_RED_2`: main 100, side 100.
  - `SIDE_GREEN`: main 100, side 001.
  - `SIDE_YELLOW`: main 100, side 010.
- Any unused state encoding recovers to `ALL_RED_2` on the next edge with `cnt`=0.

## Timing
- Reset (`rst_n`=0, asynchronous, may occur mid-phase): state=`ALL_RED_2`, `cnt`=0, `ped_pending`=0, walk flag=0, toggle=0.
- Outputs during and after reset: `main_rgy`=100, `side_rgy`=100, `ped_walk`=0, `phase`=`ALL_RED_2`.
- After `rst_n` rises, the lamps are all-red for `T_AR` cycles, then `MAIN_GREEN`.
- Input-to-transition latency is 1 edge: a request seen at an expired `MAIN_GREEN` moves to yellow on that edge.
- Outputs change in the same cycle as the state, with no extra register stage.
- Inputs are assumed synchronous to `clk`. Synchronisers are the integrator's responsibility.

## Structure
- Package `traffic_pkg`:
  - State typedef and encodings: `MAIN_GREEN`=0, `MAIN_YELLOW`=1, `ALL_RED_1`=2, `SIDE_GREEN`=3, `SIDE_YELLOW`=4, `ALL_RED_2`=5, `FLASH`=6.
  - RGY lamp constants: `LAMP_RED`=100, `LAMP_YEL`=010, `LAMP_GRN`=001, `LAMP_OFF`=000.
- Single module. The lamp decode may be split into the sub-module `traffic_lamp_decode` (purely combinational: state, toggle, walk → lamps).

## Test plan
Parameters: T_MG=8, T_MG_EXT=16, T_SG=6, T_Y=3, T_AR=2, T_WALK=4, T_FLASH=2.
- **Idle after reset, no inputs:** 2 cycles all-red, then `main_rgy`=001 and `side_rgy`=100 held for ≥100 cycles.
- **`side_req`=1 constant:** repeating 8/3/2/6/3/2-cycle sequence, one period = 24 cycles, with `ped_walk`=0 throughout.
- **`heavy_main`=1:** main green lasts 16 cycles. Dropping `heavy_main` at `cnt`=10 with `side_req`=1 gives `MAIN_YELLOW` on the next edge.
- **`ped_req` pulse at cycle 5 of main green, no `side_req`:** yellow at cycle 8, then `ped_walk`=1 for the first 4 of the 6 side-green cycles and `ped_pending` 1→0 entering side green. A second pulse during side green is served in the following cycle.
- **`night_mode` raised during main green with `side_req`=1:** enters `FLASH` after `ALL_RED_1`, main yellow toggles every 2 cycles, side red toggles in phase. Dropping `night_mode` gives 2 cycles all-red, then main green.
- **`rst_n` low at cycle 3 of `SIDE_GREEN` with walk active:** lamps go all-red and `ped_walk`=0 immediately (asynchronously), `ped_pending`=0, and the reset-release sequence matches the first scenario.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared state encodings and lamp constants for the intersection controller.
package traffic_pkg;

    // Phase encoding; values are exported on the phase output for monitoring.
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_1   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_2   = 3'd5,
        FLASH       = 3'd6
    } state_t;

    // Lamp bundles are ordered {red, yellow, green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_lamp_decode.sv
// Purely combinational lamp decode: phase, flash toggle and walk enable to lamp drivers.
module traffic_lamp_decode
    import traffic_pkg::*;
(
    input  state_t     i_state,
    input  logic       i_tog,
    input  logic       i_walk,
    output logic [2:0] o_main_rgy,
    output logic [2:0] o_side_rgy,
    output logic       o_ped_walk
);

    // Default to all-red so any unexpected encoding shows a safe aspect.
    always_comb begin
        o_main_rgy = LAMP_RED;
        o_side_rgy = LAMP_RED;
        o_ped_walk = 1'b0;
        case (i_state)
            MAIN_GREEN:  o_main_rgy = LAMP_GRN;
            MAIN_YELLOW: o_main_rgy = LAMP_YEL;
            SIDE_GREEN: begin
                o_side_rgy = LAMP_GRN;
                o_ped_walk = i_walk;
            end
            SIDE_YELLOW: o_side_rgy = LAMP_YEL;
            FLASH: begin
                o_main_rgy = i_tog ? LAMP_YEL : LAMP_OFF;
                o_side_rgy = i_tog ? LAMP_RED : LAMP_OFF;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-approach intersection controller: main/side road sequencing, pedestrian
// request latch, all-red clearance, heavy-traffic extension and night flash.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_MG     = 32,
    parameter int unsigned T_MG_EXT = 64,
    parameter int unsigned T_SG     = 16,
    parameter int unsigned T_Y      = 4,
    parameter int unsigned T_AR     = 2,
    parameter int unsigned T_WALK   = 8,
    parameter int unsigned T_FLASH  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       heavy_main,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] main_rgy,
    output logic [2:0] side_rgy,
    output logic       ped_walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    // Terminal counts (duration minus one) in counter width.
    localparam logic [CNT_W-1:0] C_MG_TC     = CNT_W'(T_MG - 1);
    localparam logic [CNT_W-1:0] C_MG_EXT_TC = CNT_W'(T_MG_EXT - 1);
    localparam logic [CNT_W-1:0] C_SG_TC     = CNT_W'(T_SG - 1);
    localparam logic [CNT_W-1:0] C_Y_TC      = CNT_W'(T_Y - 1);
    localparam logic [CNT_W-1:0] C_AR_TC     = CNT_W'(T_AR - 1);
    localparam logic [CNT_W-1:0] C_FLASH_TC  = CNT_W'(T_FLASH - 1);
    // One bit wider so a walk time of 2^CNT_W still compares correctly.
    localparam logic [CNT_W:0]   C_WALK      = (CNT_W+1)'(T_WALK);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_mg_tc;
    logic             r_ped_pending;
    logic             w_ped_pending_next;
    logic             r_walk;
    logic             w_walk_next;
    logic             r_tog;
    logic             w_tog_next;
    logic             w_enter_sg;
    logic             w_walk_on;

    // Main green terminal is re-evaluated every cycle so dropping heavy_main can expire it at once.
    assign w_mg_tc = heavy_main ? C_MG_EXT_TC : C_MG_TC;

    // State, phase counter and latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ALL_RED_2;
            r_cnt         <= '0;
            r_ped_pending <= 1'b0;
            r_walk        <= 1'b0;
            r_tog         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_ped_pending <= w_ped_pending_next;
            r_walk        <= w_walk_next;
            r_tog         <= w_tog_next;
        end
    end

    // Next-state and counter: counter clears on every state change, else increments.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        case (r_state)
            MAIN_GREEN: begin
                if ((r_cnt >= w_mg_tc) && (side_req || r_ped_pending)) begin
                    w_state_next = MAIN_YELLOW;
                    w_cnt_next   = '0;
                end else if (r_cnt >= C_MG_EXT_TC) begin
                    // Holding with no demand: saturate rather than wrap.
                    w_cnt_next = C_MG_EXT_TC;
                end
            end
            MAIN_YELLOW: begin
                if (r_cnt == C_Y_TC) begin
                    w_state_next = ALL_RED_1;
                    w_cnt_next   = '0;
                end
            end
            ALL_RED_1: begin
                if (r_cnt == C_AR_TC) begin
                    w_state_next = night_mode ? FLASH : SIDE_GREEN;
                    w_cnt_next   = '0;
                end
            end
            SIDE_GREEN: begin
                if (r_cnt == C_SG_TC) begin
                    w_state_next = SIDE_YELLOW;
                    w_cnt_next   = '0;
                end
            end
            SIDE_YELLOW: begin
                if (r_cnt == C_Y_TC) begin
                    w_state_next = ALL_RED_2;
                    w_cnt_next   = '0;
                end
            end
            ALL_RED_2: begin
                if (r_cnt == C_AR_TC) begin
                    w_state_next = night_mode ? FLASH : MAIN_GREEN;
                    w_cnt_next   = '0;
                end
            end
            FLASH: begin
                if (!night_mode) begin
                    w_state_next = ALL_RED_2;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_FLASH_TC) begin
                    // Counter doubles as the flash half-period timer.
                    w_cnt_next = '0;
                end
            end
            default: begin
                w_state_next = ALL_RED_2;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Pedestrian latch, walk grant and flash toggle updates.
    always_comb begin
        w_enter_sg         = (r_state != SIDE_GREEN) && (w_state_next == SIDE_GREEN);
        // A press on the serving edge stays latched for the next cycle of the sequence.
        w_ped_pending_next = ped_req | (r_ped_pending & ~w_enter_sg);
        w_walk_next        = 1'b0;
        if (w_enter_sg) begin
            w_walk_next = r_ped_pending;
        end else if (w_state_next == SIDE_GREEN) begin
            w_walk_next = r_walk;
        end
        w_tog_next = 1'b0;
        if (w_state_next == FLASH) begin
            if (r_state != FLASH) begin
                w_tog_next = 1'b1;
            end else if (r_cnt == C_FLASH_TC) begin
                w_tog_next = ~r_tog;
            end else begin
                w_tog_next = r_tog;
            end
        end
    end

    assign w_walk_on = r_walk && ({1'b0, r_cnt} < C_WALK);

    traffic_lamp_decode u_lamp_decode (
        .i_state    (r_state),
        .i_tog      (r_tog),
        .i_walk     (w_walk_on),
        .o_main_rgy (main_rgy),
        .o_side_rgy (side_rgy),
        .o_ped_walk (ped_walk)
    );

    assign ped_pending = r_ped_pending;
    assign phase       = r_state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Scoreboard bench: driver pushes expected outputs from a phase/age reference
// model; a monitor pops and compares on every cycle.
module tb_traffic_intersection_ctrl;
    import traffic_pkg::*;

    localparam int T_MG = 8, T_MG_EXT = 16, T_SG = 6, T_Y = 3, T_AR = 2, T_WALK = 4, T_FLASH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       heavy_main = 1'b0, side_req = 1'b0, ped_req = 1'b0, night_mode = 1'b0;
    logic [2:0] main_rgy, side_rgy, phase;
    logic       ped_walk, ped_pending;

    traffic_intersection_ctrl #(
        .CNT_W(8), .T_MG(T_MG), .T_MG_EXT(T_MG_EXT), .T_SG(T_SG), .T_Y(T_Y),
        .T_AR(T_AR), .T_WALK(T_WALK), .T_FLASH(T_FLASH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .heavy_main(heavy_main), .side_req(side_req),
        .ped_req(ped_req), .night_mode(night_mode), .main_rgy(main_rgy),
        .side_rgy(side_rgy), .ped_walk(ped_walk), .ped_pending(ped_pending), .phase(phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] main;
        logic [2:0] side;
        logic       walk;
        logic       pend;
        logic [2:0] ph;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_no = 0;
    bit   done = 0;

    // Reference model: current phase, cycles spent in it, pending request, walk grant.
    state_t m_ph;
    int     m_age;
    bit     m_pend, m_grant;

    function automatic int dur(state_t s);
        case (s)
            MAIN_YELLOW, SIDE_YELLOW: return T_Y;
            ALL_RED_1, ALL_RED_2:     return T_AR;
            SIDE_GREEN:               return T_SG;
            default:                  return 1;
        endcase
    endfunction

    function automatic state_t succ(state_t s);
        case (s)
            MAIN_YELLOW: return ALL_RED_1;
            ALL_RED_1:   return SIDE_GREEN;
            SIDE_GREEN:  return SIDE_YELLOW;
            SIDE_YELLOW: return ALL_RED_2;
            default:     return MAIN_GREEN;
        endcase
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        bit   tog;
        e.main = 3'b100; e.side = 3'b100; e.walk = 1'b0; e.pend = m_pend; e.ph = m_ph;
        case (m_ph)
            MAIN_GREEN:  e.main = 3'b001;
            MAIN_YELLOW: e.main = 3'b010;
            SIDE_GREEN: begin
                e.side = 3'b001;
                e.walk = m_grant && (m_age < T_WALK);
            end
            SIDE_YELLOW: e.side = 3'b010;
            FLASH: begin
                tog = ((m_age / T_FLASH) % 2) == 0;
                e.main = {1'b0, tog, 1'b0};
                e.side = {tog, 2'b00};
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic m_reset();
        m_ph = ALL_RED_2; m_age = 0; m_pend = 0; m_grant = 0;
    endtask

    task automatic m_step(input bit h, input bit s, input bit p, input bit n);
        state_t nph  = m_ph;
        int     nage = m_age + 1;
        if (m_ph == MAIN_GREEN) begin
            if (m_age >= (h ? T_MG_EXT : T_MG) - 1 && (s || m_pend)) begin
                nph = MAIN_YELLOW; nage = 0;
            end
        end else if (m_ph == FLASH) begin
            if (!n) begin
                nph = ALL_RED_2; nage = 0;
            end
        end else if (m_age == dur(m_ph) - 1) begin
            nage = 0;
            nph  = ((m_ph == ALL_RED_1 || m_ph == ALL_RED_2) && n) ? FLASH : succ(m_ph);
        end
        if (nph == SIDE_GREEN && m_ph != SIDE_GREEN) begin
            m_grant = m_pend;
            m_pend  = p;
        end else begin
            m_pend = p | m_pend;
        end
        m_ph = nph; m_age = nage;
    endtask

    // One clock cycle of stimulus; inputs (and reset) change on the falling edge.
    task automatic cyc(input bit r, input bit h, input bit s, input bit p, input bit n);
        @(negedge clk);
        rst_n = r; heavy_main = h; side_req = s; ped_req = p; night_mode = n;
        if (!r) m_reset();
        q.push_back(m_expect());
        if (r) m_step(h, s, p, n);
        cyc_no++;
    endtask

    task automatic bound_fail(input string name);
        total++; bad++;
        $display("FAIL %s: bound expired at cycle %0d, actual=timeout required=reached", name, cyc_no);
    endtask

    // Advance until main green has been held for n cycles, forcing a cycle with side_req when past it.
    task automatic wait_mg_age(input int n);
        int k;
        for (k = 0; k < 300; k++) begin
            if (m_ph == MAIN_GREEN && m_age == n) break;
            cyc(1, 0, (m_ph == MAIN_GREEN && m_age > n), 0, 0);
        end
        if (k == 300) bound_fail("wait_mg_age");
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc_no, act, req);
        end
    endtask

    // Monitor: pop one expectation per cycle, mid-cycle, and compare.
    initial begin
        exp_t e;
        logic [2:0] last_ph = 3'd7;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("main_rgy",    main_rgy,    e.main);
                chk("side_rgy",    side_rgy,    e.side);
                chk("ped_walk",    ped_walk,    e.walk);
                chk("ped_pending", ped_pending, e.pend);
                chk("phase",       phase,       e.ph);
                if (phase != last_ph)
                    $display("cycle %0d phase=%0d main=%b side=%b walk=%b pend=%b rst_n=%b",
                             cyc_no, phase, main_rgy, side_rgy, ped_walk, ped_pending, rst_n);
                last_ph = phase;
            end else if (!done) begin
                bound_fail("scoreboard_empty");
            end
        end
    end

    bit rh, rs, rn, rp, rr;

    initial begin
        int k;
        m_reset();
        // Reset held, then idle: all-red for T_AR then main green held.
        repeat (3)   cyc(0, 0, 0, 0, 0);
        repeat (110) cyc(1, 0, 0, 0, 0);
        // Constant side demand: full repeating sequence.
        repeat (60)  cyc(1, 0, 1, 0, 0);
        // Heavy main extension, then drop heavy at cnt=10 with side demand.
        repeat (60)  cyc(1, 1, 1, 0, 0);
        wait_mg_age(0);
        for (k = 0; k < 10; k++) cyc(1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        repeat (20)  cyc(1, 0, 0, 0, 0);
        // Pedestrian pulse at main-green cycle 5, second pulse during side green.
        wait_mg_age(5);
        cyc(1, 0, 0, 1, 0);
        for (k = 0; k < 100 && !(m_ph == SIDE_GREEN && m_age == 2); k++) cyc(1, 0, 0, 0, 0);
        if (k == 100) bound_fail("wait_side_green");
        cyc(1, 0, 0, 1, 0);
        repeat (40)  cyc(1, 0, 0, 0, 0);
        // Night mode raised during main green with side demand.
        wait_mg_age(2);
        for (k = 0; k < 60 && m_ph != FLASH; k++) cyc(1, 0, 1, 0, 1);
        if (k == 60) bound_fail("wait_flash");
        repeat (10)  cyc(1, 0, 0, 1, 1);
        repeat (15)  cyc(1, 0, 0, 0, 0);
        // Asynchronous reset during side green with walk lit.
        wait_mg_age(1);
        cyc(1, 0, 0, 1, 0);
        for (k = 0; k < 100 && !(m_ph == SIDE_GREEN && m_age == 3); k++) cyc(1, 0, 0, 0, 0);
        if (k == 100) bound_fail("wait_walk");
        repeat (3)   cyc(0, 0, 0, 0, 0);
        repeat (110) cyc(1, 0, 0, 0, 0);
        // Randomized level segments with pedestrian pulses and rare resets.
        for (k = 0; k < 3000; ) begin
            int len;
            len = $urandom_range(1, 30);
            rh  = ($urandom_range(0, 1) == 1);
            rs  = ($urandom_range(0, 2) == 0);
            rn  = ($urandom_range(0, 9) == 0);
            for (int j = 0; j < len; j++) begin
                rp = ($urandom_range(0, 15) == 0);
                rr = ($urandom_range(0, 399) != 0);
                cyc(rr, rh, rs, rp, rn);
                k++;
            end
        end
        done = 1;
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
